// File: rtl/sd_dma_pkg.sv
// Shared SD host DMA definitions: transfer-type codes and the block sequencer state encoding.
// The STOP state exists only when AUTO_CMD12_EN is defined.
package sd_dma_pkg;

  localparam logic [1:0] SINGLE_TRANSFER        = 2'b00;
  localparam logic [1:0] INFINITE_TRANSFER      = 2'b01;
  localparam logic [1:0] MULTIPLE_TRANSFER      = 2'b10;
  localparam logic [1:0] STOP_MULTIPLE_TRANSFER = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    XFER    = 3'd1,
    BLK_END = 3'd2,
`ifdef AUTO_CMD12_EN
    STOP    = 3'd3,
`endif
    DONE    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/block_word_counter.sv
// Word counter for one data block: clear has priority over increment,
// last_word flags the final word of a block of block_size words.
module block_word_counter #(
  parameter int BLOCK_SIZE_W = 12
) (
  input  logic                    CLK,
  input  logic                    RESET_L,
  input  logic                    clear,
  input  logic                    inc,
  input  logic [BLOCK_SIZE_W-1:0] block_size,
  output logic                    last_word
);

  logic [BLOCK_SIZE_W-1:0] count;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + BLOCK_SIZE_W'(1);
    end
  end

  assign last_word = (count == block_size - BLOCK_SIZE_W'(1));

endmodule

// File: rtl/transfer_block_sequencer.sv
// Block-transfer sequencer for the SD host DMA (single, multiple, infinite modes).
// Define AUTO_CMD12_EN to compile in the STOP state and the automatic CMD12 request.
module transfer_block_sequencer
  import sd_dma_pkg::*;
#(
  parameter int BLOCK_COUNT_W = 16,
  parameter int BLOCK_SIZE_W  = 12
) (
  input  logic                     CLK,
  input  logic                     RESET_L,
  input  logic                     Start,
  input  logic                     Multi_Single_Block_Select,
  input  logic                     Block_Count_Enable,
  input  logic [BLOCK_COUNT_W-1:0] Block_Count,
  input  logic [BLOCK_SIZE_W-1:0]  Block_Size,
  input  logic                     Stop_Request,
  input  logic                     Word_Done,
  input  logic                     Auto_Stop_Ack,
  output logic [1:0]               Transfer_Type,
  output logic                     Busy,
  output logic                     Block_Start,
  output logic                     Block_End,
  output logic [BLOCK_COUNT_W-1:0] Blocks_Remaining,
  output logic                     Transfer_Complete,
  output logic                     Config_Error,
  output logic                     Auto_Stop_Req,
  output seq_state_e               debug_state
);

  // Handshake: Word_Done is a combined valid/ready strobe from the data path; each
  // cycle it is high exactly one word has moved. It is only counted in XFER.

  seq_state_e               state_q, state_d;
  logic                     stop_q, stop_d;
  logic                     multi_q, multi_d;
  logic [BLOCK_SIZE_W-1:0]  size_q, size_d;
  logic [1:0]               type_d;
  logic [BLOCK_COUNT_W-1:0] rem_d;
  logic                     busy_d, block_start_d, block_end_d, complete_d, cfg_err_d;
  logic                     cnt_clear, cnt_inc, last_word;
  logic                     stop_ok, stop_any, more_blocks;
`ifdef AUTO_CMD12_EN
  logic                     auto_req_d;
`endif

  block_word_counter #(.BLOCK_SIZE_W(BLOCK_SIZE_W)) u_word_counter (
    .CLK        (CLK),
    .RESET_L    (RESET_L),
    .clear      (cnt_clear),
    .inc        (cnt_inc),
    .block_size (size_q),
    .last_word  (last_word)
  );

  // Stops only matter for multiple/infinite transfers; single mode runs to its end.
  assign stop_ok     = Stop_Request && (Transfer_Type != SINGLE_TRANSFER);
  assign stop_any    = stop_q || stop_ok;
  assign more_blocks = multi_q ? (Blocks_Remaining > BLOCK_COUNT_W'(1))
                               : (Transfer_Type == INFINITE_TRANSFER);

  always_comb begin
    state_d       = state_q;
    stop_d        = stop_q;
    multi_d       = multi_q;
    size_d        = size_q;
    type_d        = Transfer_Type;
    rem_d         = Blocks_Remaining;
    busy_d        = Busy;
    block_start_d = 1'b0;
    block_end_d   = 1'b0;
    complete_d    = 1'b0;
    cfg_err_d     = 1'b0;
    cnt_clear     = 1'b0;
    cnt_inc       = 1'b0;
`ifdef AUTO_CMD12_EN
    auto_req_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (Start) begin
          if ((Block_Size == '0) ||
              (Multi_Single_Block_Select && Block_Count_Enable && (Block_Count == '0))) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d       = XFER;
            busy_d        = 1'b1;
            block_start_d = 1'b1;
            size_d        = Block_Size;
            cnt_clear     = 1'b1;
            multi_d       = Multi_Single_Block_Select && Block_Count_Enable;
            rem_d         = '0;
            if (!Multi_Single_Block_Select) begin
              type_d = SINGLE_TRANSFER;
            end else if (!Block_Count_Enable) begin
              type_d = INFINITE_TRANSFER;
            end else begin
              type_d = MULTIPLE_TRANSFER;
              rem_d  = Block_Count;
            end
          end
        end
      end
      XFER: begin
        if (stop_ok) begin
          stop_d = 1'b1;
          type_d = STOP_MULTIPLE_TRANSFER;
        end
        if (Word_Done) begin
          cnt_inc = 1'b1;
          if (last_word) begin
            cnt_clear   = 1'b1;
            state_d     = BLK_END;
            block_end_d = 1'b1;
          end
        end
      end
      BLK_END: begin
        if (stop_ok) begin
          stop_d = 1'b1;
          type_d = STOP_MULTIPLE_TRANSFER;
        end
        if (multi_q) begin
          rem_d = Blocks_Remaining - BLOCK_COUNT_W'(1);
        end
        if (more_blocks && !stop_any) begin
          state_d       = XFER;
          block_start_d = 1'b1;
        end
`ifdef AUTO_CMD12_EN
        else if (multi_q || stop_any) begin
          state_d    = STOP;
          auto_req_d = 1'b1;
        end
`endif
        else begin
          state_d    = DONE;
          complete_d = 1'b1;
        end
      end
`ifdef AUTO_CMD12_EN
      STOP: begin
        auto_req_d = 1'b1;
        if (Auto_Stop_Ack) begin
          auto_req_d = 1'b0;
          state_d    = DONE;
          complete_d = 1'b1;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q           <= IDLE;
      stop_q            <= 1'b0;
      multi_q           <= 1'b0;
      size_q            <= '0;
      Transfer_Type     <= SINGLE_TRANSFER;
      Blocks_Remaining  <= '0;
      Busy              <= 1'b0;
      Block_Start       <= 1'b0;
      Block_End         <= 1'b0;
      Transfer_Complete <= 1'b0;
      Config_Error      <= 1'b0;
    end else begin
      state_q           <= state_d;
      stop_q            <= stop_d;
      multi_q           <= multi_d;
      size_q            <= size_d;
      Transfer_Type     <= type_d;
      Blocks_Remaining  <= rem_d;
      Busy              <= busy_d;
      Block_Start       <= block_start_d;
      Block_End         <= block_end_d;
      Transfer_Complete <= complete_d;
      Config_Error      <= cfg_err_d;
    end
  end

`ifdef AUTO_CMD12_EN
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      Auto_Stop_Req <= 1'b0;
    end else begin
      Auto_Stop_Req <= auto_req_d;
    end
  end
`else
  logic unused_auto_stop_ack;
  assign unused_auto_stop_ack = Auto_Stop_Ack;
  assign Auto_Stop_Req        = 1'b0;
`endif

  assign debug_state = state_q;

endmodule

// File: doc/transfer_block_sequencer.md
# transfer_block_sequencer

Parametrised block-transfer sequencer for the SD Host DMA. It decodes the transfer mode from Multi_Single_Block_Select and Block_Count_Enable, then sequences single, multiple and infinite block transfers word by word. It tracks remaining blocks, honours stop requests at block boundaries and optionally issues an automatic CMD12 request. It sits between the register file (mode, count, size) and the DMA data path (per-word handshake).

## Interface
- BLOCK_COUNT_W, default 16: width of the block count.
- BLOCK_SIZE_W, default 12: width of the block size, counted in data-path words.
- CLK, input, 1: clock, rising edge.
- RESET_L, input, 1: reset, asynchronous, active-low.
- Start, input, 1: single-cycle command to begin a transfer; sampled only in IDLE.
- Multi_Single_Block_Select, input, 1: 1 = multiple-block transfer.
- Block_Count_Enable, input, 1: 1 = Block_Count is valid.
- Block_Count, input, BLOCK_COUNT_W: number of blocks; sampled at Start.
- Block_Size, input, BLOCK_SIZE_W: words per block; sampled at Start.
- Stop_Request, input, 1: asks the sequencer to end the transfer at the next block boundary.
- Word_Done, input, 1: one data word transferred this cycle.
- Auto_Stop_Ack, input, 1: CMD12 issued (used only when AUTO_CMD12_EN is defined).
- Transfer_Type, output, 2: 00 single, 01 infinite, 10 multiple, 11 stopped multiple.
- Busy, output, 1: transfer in progress.
- Block_Start, output, 1: one-cycle pulse, first cycle of each block.
- Block_End, output, 1: one-cycle pulse after the last word of each block.
- Blocks_Remaining, output, BLOCK_COUNT_W: blocks still to transfer.
- Transfer_Complete, output, 1: one-cycle pulse at the end of the transfer.
- Config_Error, output, 1: one-cycle pulse when Start is rejected.
- Auto_Stop_Req, output, 1: level request for CMD12.

## Operation
- States: IDLE, XFER, BLK_END, STOP (present only with AUTO_CMD12_EN), DONE.
- Mode decode at Start:
  - Multi_Single_Block_Select=0 gives single mode (type 00, 1 block).
  - Multi_Single_Block_Select=1 with Block_Count_Enable=0 gives infinite mode (type 01).
  - Multi_Single_Block_Select=1 with Block_Count_Enable=1 gives multiple mode (type 10, Block_Count blocks).
- Rejected Start: if Block_Size==0, or if mode is multiple and Block_Count==0, the block pulses Config_Error, stays in IDLE and leaves Transfer_Type unchanged.
- IDLE: on an accepted Start, latch the mode, count and size, and go to XFER.
- XFER: the word counter increments on each Word_Done. A Word_Done when the counter equals Block_Size-1 moves the state to BLK_END. Word_Done is ignored in every other state.
- BLK_END: lasts one cycle.
  - Multiple mode: Blocks_Remaining decrements.
  - Next state is XFER if more blocks remain and no stop is latched.
  - Otherwise, the next state is STOP (multiple or stopped mode with AUTO_CMD12_EN) or DONE (all other cases).
- Stop_Request:
  - Latched when asserted in XFER or BLK_END, in multiple or infinite mode.
  - Latching sets Transfer_Type to 11.
  - Ignored in single mode and in IDLE.
  - If Start and Stop_Request arrive in the same IDLE cycle, Start is taken and the stop is dropped.
- Infinite mode ends only through a stop. Blocks_Remaining holds 0 in infinite mode.
- Start while Busy is ignored.
- DONE: Transfer_Complete pulses, then the state returns to IDLE. Transfer_Type holds until the next accepted Start.

## Timing
- Reset values: Transfer_Type=00, Blocks_Remaining=0, and all other outputs 0. The state and the latched stop clear to IDLE immediately on RESET_L low, including in the middle of a transfer.
- Start accepted in cycle N: Busy=1 and Block_Start=1 in cycle N+1. In multiple mode, Blocks_Remaining=Block_Count in cycle N+1.
- Final Word_Done of a block in cycle M:
  - Block_End=1 in cycle M+1.
  - If another block follows, Block_Start=1 in cycle M+2.
  - If the transfer ends (without auto CMD12), Transfer_Complete=1 in cycle M+2 and Busy=0 in cycle M+3.
- Stop latched in the same cycle as the final Word_Done of a block: honoured at that same boundary.
- All outputs are registered.

## Configuration
- AUTO_CMD12_EN defined: after a multiple or stopped transfer ends, STOP raises Auto_Stop_Req and holds it until Auto_Stop_Ack is sampled high. Auto_Stop_Req is high for at least one cycle. DONE follows in the next cycle.
- AUTO_CMD12_EN undefined: the STOP state is not compiled, Auto_Stop_Req is tied to 0 and Auto_Stop_Ack is ignored.

## Structure
- Shared package sd_dma_pkg holds:
  - Transfer-type constants: SINGLE_TRANSFER, INFINITE_TRANSFER, MULTIPLE_TRANSFER, STOP_MULTIPLE_TRANSFER.
  - The sequencer state encoding.
- Sub-module block_word_counter: a BLOCK_SIZE_W counter with clear, increment and last-word flag.

## Test plan
- Single mode, Block_Size=4, four Word_Done: Transfer_Type=00, one Block_Start/Block_End pair, Transfer_Complete 2 cycles after the 4th word.
- Multiple mode, Block_Count=3, Block_Size=2: Blocks_Remaining goes 3→2→1→0, three Block_End pulses, Transfer_Type=10, Auto_Stop_Req asserted when AUTO_CMD12_EN is defined.
- Infinite mode, Block_Size=2, Stop_Request during block 5: block 5 completes, Transfer_Type=11, Transfer_Complete follows, Blocks_Remaining stays 0.
- Multiple mode with Block_Count=0, and Start with Block_Size=0: Config_Error pulses, Busy stays 0, Transfer_Type unchanged.
- RESET_L low in the middle of block 2 of a 4-block transfer: all outputs 0 immediately. A new Start after release runs normally.
- AUTO_CMD12_EN defined, Auto_Stop_Ack delayed 5 cycles: Auto_Stop_Req held 5 cycles, Transfer_Complete in the cycle after the ack.
